input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//   Multi-channel conditioning front end between raw async pad inputs (ui_in/uio_in) and user logic.
//   Per channel: N-stage synchroniser, runtime polarity select, debounce filter, edge detection.
//   Runtime mode selects what drives dout: level, toggle or one-shot pulse.
//   Sticky event flags are write-1-to-clear and are read by user logic.
// PARAMETERS
//   CHANNELS     8   number of independent input channels (>=1)
//   SYNC_STAGES  2   synchroniser flops per channel (>=2)
//   DB_LIMIT     8   consecutive differing samples required to accept a new level (>=1)
// PORTS
//   clk           in   1         single clock; all state on rising edge
//   rst_n         in   1         asynchronous, active-low reset
//   en            in   1         1 = filter/event state advances; 0 = frozen
//   din           in   CHANNELS  raw asynchronous inputs
//   invert        in   CHANNELS  per-channel polarity; 1 = invert after synchroniser
//   mode          in   2         00 SYNC, 01 LEVEL, 10 TOGGLE, 11 PULSE (common to all channels)
//   clear         in   CHANNELS  write-1-to-clear for event_sticky
//   dout          out  CHANNELS  conditioned output; meaning set by mode
//   rise          out  CHANNELS  1-cycle pulse when the debounced level goes 0->1
//   fall          out  CHANNELS  1-cycle pulse when the debounced level goes 1->0
//   event_sticky  out  CHANNELS  set by rise|fall; held until cleared
// BEHAVIOUR
//   - Reset: async assert clears all state immediately, mid-operation included.
//     Cleared state: sync chain, db level, counters, toggle, sticky.
//     All outputs read 0 during reset and after release.
//   - Synchroniser: runs every cycle, including when en=0.
//     s[i] = last_stage[i] ^ invert[i] (combinational).
//   - Debounce, mode != SYNC, en=1:
//     - s==db: cnt <= 0.
//     - s!=db and cnt==DB_LIMIT-1: db <= s, cnt <= 0.
//     - s!=db otherwise: cnt++.
//     - Counter width max(1, $clog2(DB_LIMIT)).
//     - Glitches shorter than DB_LIMIT cycles leave no trace.
//   - Latency, LEVEL mode: clean din step moves dout on the (SYNC_STAGES+DB_LIMIT)th edge.
//     Counted from the first edge that samples the new value.
//   - SYNC mode: db <= s every enabled cycle; cnt held 0; latency SYNC_STAGES+1 edges.
//   - rise/fall are registered on the same edge as the db change. Each is high for exactly 1 cycle.
//   - dout per mode:
//     - SYNC/LEVEL: db.
//     - TOGGLE: tog, which flips on each rise; fall is ignored.
//     - PULSE: rise.
//   - Sticky: set on rise|fall. Cleared by clear[i]. Set wins over a simultaneous clear.
//   - en=0:
//     - db, cnt, tog and sticky hold.
//     - rise/fall are forced 0; clear is still honoured.
//   - Mode change: takes effect next edge. No state is flushed, except cnt, which is zeroed while mode==SYNC.
//   - invert change: acts like an input edge and is debounced normally.
//   - After reset with invert[i]=1 and an idle-low pad: s=1 != db=0.
//     One rise is produced SYNC_STAGES+DB_LIMIT edges after reset release. This is intended.
// STRUCTURE
//   - input_cond_pkg: mode localparams MODE_SYNC/MODE_LEVEL/MODE_TOGGLE/MODE_PULSE and a counter-width function.
//   - Sub-module input_cond_channel: one channel (sync, debounce, edge, toggle, sticky).
//     Instantiated CHANNELS times in a generate loop.
//     Top level contains only the generate loop and output muxing.
// TESTING (CHANNELS=4, SYNC_STAGES=2, DB_LIMIT=4)
//   1. rst_n=0 with din=4'hF -> all outputs 0.
//      Release, mode=01, din=4'b0001 -> dout[0]=1 on edge 6; rise[0] 1 cycle; event_sticky=4'b0001.
//   2. din[1] high 3 cycles -> no dout/rise/event change.
//      din[1] high 4+ cycles -> dout[1]=1 after 6 edges.
//   3. mode=10, two clean presses on ch2 -> dout[2] goes 0->1->0. Releases do not toggle.
//   4. mode=11, din[3] held high 20 cycles -> exactly one 1-cycle dout[3] pulse.
//   5. clear[0]=1 on the rise[0] cycle -> sticky stays 1. clear[0]=1 next cycle -> 0.
//   6. Mid-count en=0 for 10 cycles -> counter frozen; remaining edges complete after en=1.
//      Reset with invert=4'b0001, din=0 -> rise[0] on edge 6 after release.
//      rst_n pulse mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/input_cond_pkg.sv
// Shared definitions for the input conditioner: output mode encodings and
// the debounce counter sizing helper.
package input_cond_pkg;

  localparam logic [1:0] MODE_SYNC   = 2'b00;
  localparam logic [1:0] MODE_LEVEL  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_PULSE  = 2'b11;

  // Debounce counter width: enough to hold DB_LIMIT-1, never narrower than 1 bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage : input_cond_pkg

// File: rtl/input_cond_channel.sv
// One conditioning channel: synchroniser, polarity select, debounce filter,
// edge detection, toggle state and sticky event flag.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_LIMIT    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       din_i,
  input  logic       invert_i,
  input  logic [1:0] mode_i,
  input  logic       clear_i,
  output logic       db_o,
  output logic       tog_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       sticky_o
);

  localparam int                CW      = cnt_width(DB_LIMIT);
  localparam logic [CW-1:0]     CNT_MAX = CW'(DB_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  // Fills with ones after reset; the filter only trusts the synchroniser once
  // every stage holds a real pad sample, so post-reset latency matches a
  // normal input step.
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   s;
  logic                   advance;

  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tog_q, tog_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          sticky_q, sticky_d;

  // Synchroniser and warm-up chain shift every cycle, regardless of en.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1] ^ invert_i;
  assign advance = en_i & prime_q[SYNC_STAGES-1];

  // Next-state for debounce, edges, toggle and sticky flag.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    db_d  = db_q;
    cnt_d = cnt_q;
    if (mode_i == MODE_SYNC) begin
      cnt_d = '0;
      if (advance) db_d = s;
    end else if (advance) begin
      if (s == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        db_d  = s;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // db can only move while enabled, so the edges are zero whenever en=0.
    rise_d   = ~db_q & db_d;
    fall_d   = db_q & ~db_d;
    tog_d    = tog_q ^ rise_d;
    // Set comes from the visible edge pulse and overrides a clear in the same cycle.
    sticky_d = sticky_q & ~clear_i;
    if (en_i) sticky_d = sticky_d | rise_q | fall_q;
  end

  // Conditioning state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b0;
      cnt_q    <= '0;
      tog_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      tog_q    <= tog_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

  assign db_o     = db_q;
  assign tog_o    = tog_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign sticky_o = sticky_q;

endmodule : input_cond_channel

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one channel instance per pad input plus
// the mode-dependent output selection.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_LIMIT    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] invert,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] event_sticky
);

  logic [CHANNELS-1:0] db_w;
  logic [CHANNELS-1:0] tog_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_cond_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_LIMIT    (DB_LIMIT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en),
      .din_i    (din[i]),
      .invert_i (invert[i]),
      .mode_i   (mode),
      .clear_i  (clear[i]),
      .db_o     (db_w[i]),
      .tog_o    (tog_w[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i]),
      .sticky_o (event_sticky[i])
    );
  end

  // Select what dout means for the current mode.
  always_comb begin
    dout = db_w;
    case (mode)
      MODE_TOGGLE: dout = tog_w;
      MODE_PULSE:  dout = rise;
      default:     dout = db_w;
    endcase
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (CHANNELS=4, SYNC_STAGES=2, DB_LIMIT=4).
module tb_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] din;
  logic [3:0] invert;
  logic [1:0] mode;
  logic [3:0] clear;
  logic [3:0] dout;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] event_sticky;

  int n_pass;
  int n_total;

  input_conditioner #(
    .CHANNELS    (4),
    .SYNC_STAGES (2),
    .DB_LIMIT    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .din          (din),
    .invert       (invert),
    .mode         (mode),
    .clear        (clear),
    .dout         (dout),
    .rise         (rise),
    .fall         (fall),
    .event_sticky (event_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; returns 1 ns after the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; din = 4'hF; invert = 4'h0; mode = 2'b01; clear = 4'h0;
    tick(2);
    n_total++;
    if ({dout, rise, fall, event_sticky} !== 16'h0)
      $display("FAIL reset_outputs: got %h want 0000", {dout, rise, fall, event_sticky});
    else n_pass++;
    din = 4'b0001;
    rst_n = 1'b1;
    tick(5);
    n_total++;
    if (dout !== 4'b0000) $display("FAIL level_edge5: dout=%b want 0000", dout);
    else n_pass++;
    tick(1);
    n_total++;
    if (dout !== 4'b0001 || rise !== 4'b0001)
      $display("FAIL level_edge6: dout=%b rise=%b want 0001/0001", dout, rise);
    else n_pass++;
    tick(1);
    n_total++;
    if (rise !== 4'b0000 || event_sticky !== 4'b0001)
      $display("FAIL rise_width: rise=%b sticky=%b want 0000/0001", rise, event_sticky);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic saw_rise1;
    saw_rise1 = 1'b0;
    din = 4'b0011;
    tick(3);
    din = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (rise[1] !== 1'b0) saw_rise1 = 1'b1;
    end
    n_total++;
    if (saw_rise1 || dout !== 4'b0001 || event_sticky !== 4'b0001)
      $display("FAIL glitch_3cyc: dout=%b sticky=%b rise1_seen=%b want 0001/0001/0",
               dout, event_sticky, saw_rise1);
    else n_pass++;
    din = 4'b0011;
    tick(5);
    n_total++;
    if (dout !== 4'b0001) $display("FAIL accept_edge5: dout=%b want 0001", dout);
    else n_pass++;
    tick(1);
    n_total++;
    if (dout !== 4'b0011 || rise !== 4'b0010)
      $display("FAIL accept_edge6: dout=%b rise=%b want 0011/0010", dout, rise);
    else n_pass++;
  endtask

  task automatic test_toggle();
    tick(1);
    clear = 4'hF;
    tick(1);
    clear = 4'h0;
    n_total++;
    if (event_sticky !== 4'b0000) $display("FAIL clear_all: sticky=%b want 0000", event_sticky);
    else n_pass++;
    mode = 2'b10;
    #1;
    n_total++;
    if (dout !== 4'b0011) $display("FAIL toggle_initial: dout=%b want 0011", dout);
    else n_pass++;
    din = 4'b0111;
    tick(6);
    n_total++;
    if (dout !== 4'b0111) $display("FAIL toggle_press1: dout=%b want 0111", dout);
    else n_pass++;
    tick(4);
    din = 4'b0011;
    tick(10);
    n_total++;
    if (dout !== 4'b0111) $display("FAIL toggle_release1: dout=%b want 0111", dout);
    else n_pass++;
    din = 4'b0111;
    tick(10);
    n_total++;
    if (dout !== 4'b0011) $display("FAIL toggle_press2: dout=%b want 0011", dout);
    else n_pass++;
    din = 4'b0011;
    tick(10);
    n_total++;
    if (dout !== 4'b0011) $display("FAIL toggle_release2: dout=%b want 0011", dout);
    else n_pass++;
  endtask

  task automatic test_pulse();
    int pulses;
    pulses = 0;
    mode = 2'b11;
    din = 4'b1011;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (dout[3] === 1'b1) pulses++;
      if (k == 6) begin
        n_total++;
        if (dout !== 4'b1000) $display("FAIL pulse_edge6: dout=%b want 1000", dout);
        else n_pass++;
      end
    end
    din = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (dout[3] === 1'b1) pulses++;
    end
    n_total++;
    if (pulses != 1) $display("FAIL pulse_count: got %0d want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_clear();
    mode = 2'b01;
    clear = 4'hF;
    tick(1);
    clear = 4'h0;
    din = 4'b0111;
    tick(6);
    n_total++;
    if (rise !== 4'b0100 || event_sticky !== 4'b0000)
      $display("FAIL clear_rise_cycle: rise=%b sticky=%b want 0100/0000", rise, event_sticky);
    else n_pass++;
    clear = 4'b0100;
    tick(1);
    n_total++;
    if (event_sticky !== 4'b0100)
      $display("FAIL clear_set_wins: sticky=%b want 0100", event_sticky);
    else n_pass++;
    tick(1);
    clear = 4'h0;
    n_total++;
    if (event_sticky !== 4'b0000)
      $display("FAIL clear_next: sticky=%b want 0000", event_sticky);
    else n_pass++;
  endtask

  task automatic test_enable();
    din = 4'b0011;
    tick(3);
    en = 1'b0;
    tick(10);
    n_total++;
    if (dout !== 4'b0111 || fall !== 4'b0000)
      $display("FAIL en_frozen: dout=%b fall=%b want 0111/0000", dout, fall);
    else n_pass++;
    en = 1'b1;
    tick(2);
    n_total++;
    if (dout !== 4'b0111) $display("FAIL en_resume2: dout=%b want 0111", dout);
    else n_pass++;
    tick(1);
    n_total++;
    if (dout !== 4'b0011 || fall !== 4'b0100)
      $display("FAIL en_resume3: dout=%b fall=%b want 0011/0100", dout, fall);
    else n_pass++;
  endtask

  task automatic test_invert_reset();
    rst_n = 1'b0; invert = 4'b0001; din = 4'b0000; mode = 2'b01; en = 1'b1;
    tick(1);
    n_total++;
    if ({dout, rise, fall, event_sticky} !== 16'h0)
      $display("FAIL inv_reset_outputs: got %h want 0000", {dout, rise, fall, event_sticky});
    else n_pass++;
    rst_n = 1'b1;
    tick(5);
    n_total++;
    if (rise !== 4'b0000) $display("FAIL inv_edge5: rise=%b want 0000", rise);
    else n_pass++;
    tick(1);
    n_total++;
    if (rise !== 4'b0001 || dout !== 4'b0001)
      $display("FAIL inv_edge6: rise=%b dout=%b want 0001/0001", rise, dout);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    din = 4'b0011;
    tick(3);
    n_total++;
    if (event_sticky !== 4'b0001 || dout !== 4'b0001)
      $display("FAIL pre_reset_state: sticky=%b dout=%b want 0001/0001", event_sticky, dout);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({dout, rise, fall, event_sticky} !== 16'h0)
      $display("FAIL async_reset: got %h want 0000", {dout, rise, fall, event_sticky});
    else n_pass++;
    tick(1);
    invert = 4'h0; din = 4'h0; mode = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_sync_mode();
    tick(3);
    din = 4'b0100;
    tick(2);
    n_total++;
    if (dout !== 4'b0000) $display("FAIL sync_edge2: dout=%b want 0000", dout);
    else n_pass++;
    tick(1);
    n_total++;
    if (dout !== 4'b0100 || rise !== 4'b0100)
      $display("FAIL sync_edge3: dout=%b rise=%b want 0100/0100", dout, rise);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_glitch();
    test_toggle();
    test_pulse();
    test_clear();
    test_enable();
    test_invert_reset();
    test_mid_reset();
    test_sync_mode();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_input_conditioner
